sccb_responder: RTL and testbench
=================================

Name: sccb_responder

Overview:
- SCCB/I2C target (responder) that emulates the OV7670 register interface: 7-bit device address, 8-bit register index, 8-bit data.
- Sits on the same two-wire bus as the camera-init I2C master. Used in simulation benches and on-board loopback to capture and verify the register init sequence without a sensor.
- Holds an internal 256x8 register file and reports every committed write on a strobe interface.

Parameters:
- DEVICE_ADDR, 7'h21, 7-bit bus address the block answers to (write byte 8'h42, read byte 8'h43).
- FILTER_LEN, 3, number of consecutive clk samples a line must be stable before its filtered value changes (range 1..15).
- AUTO_INC, 1, 1 = register index increments after each data byte (write or read); 0 = index is held.

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- rst  input  1  synchronous reset, active-high.
- scl_i  input  1  raw SCL pad input.
- sda_i  input  1  raw SDA pad input.
- sda_oen_o  output  1  SDA output enable, active-low: 0 drives SDA low, 1 releases it. The pad drives 0 only; there is no sda_o.
- wr_stb_o  output  1  one-cycle pulse when a data byte is committed to the register file.
- wr_addr_o  output  8  register index of the committed write; valid while wr_stb_o=1.
- wr_data_o  output  8  data of the committed write; valid while wr_stb_o=1.
- busy_o  output  1  high from an addressed START until STOP.
- nack_o  output  1  one-cycle pulse when the block ignores an address byte that does not match DEVICE_ADDR.

Behaviour:
- Reset: sda_oen_o=1, wr_stb_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, nack_o=0, state=IDLE, register index=0, register file all 8'h00.
- A rst mid-transfer releases SDA on the next clk and returns the block to IDLE.
- Line conditioning: 2-flop synchroniser, then the FILTER_LEN stability filter, then edge detection on the filtered lines.
  - Events are scl_rise, scl_fall, START (SDA falls while SCL=1) and STOP (SDA rises while SCL=1).
  - Latency from raw pad to event is 2+FILTER_LEN clk.
- Bit timing:
  - SDA is sampled on scl_rise.
  - The block changes its SDA drive only on scl_fall, and only in the clk cycle after the scl_fall event, so hold time is never violated.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits. After the 8th bit, bits[7:1]==DEVICE_ADDR goes to ADDR_ACK; a mismatch pulses nack_o and goes to IGNORE.
  - ADDR_ACK: drive SDA low for the 9th clock. On the 9th scl_fall, R/W=0 goes to REG_IDX and R/W=1 goes to RD_DATA.
  - REG_IDX: shift 8 bits into the register index, then go to IDX_ACK.
  - IDX_ACK: drive the ACK, then go to WR_DATA.
  - WR_DATA: shift 8 bits, then go to DATA_ACK.
  - DATA_ACK: drive the ACK.
    - On the scl_rise of the ACK bit, write the byte to the register file and pulse wr_stb_o with the index and data in use before any increment.
    - If AUTO_INC=1, increment the index (8'hFF wraps to 8'h00).
    - Return to WR_DATA.
  - RD_DATA:
    - Load regfile[index] and drive the MSB after the ACK-bit scl_fall; drive each following bit on each scl_fall.
    - A 1 bit is driven by releasing SDA.
    - After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample the master ACK on scl_rise.
    - SDA=0 (ACK): increment the index per AUTO_INC and go to RD_DATA.
    - SDA=1 (NACK): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- START in any state (repeated start) goes to DEV_ADDR and clears the bit counter; the register index is preserved. This supports the SCCB pattern of writing the index, then STOP or Sr, then reading.
- STOP in any state releases SDA and goes to IDLE; a partial byte is discarded without a write.
- busy_o is high in every state except IDLE and IGNORE.
- A STOP and an scl edge reported in the same clk: STOP wins.
- SCL is never stretched.

Decomposition:
- Shared header sccb_defs.vh:
  - SCCB_STATES enum: IDLE, DEV_ADDR, ADDR_ACK, REG_IDX, IDX_ACK, WR_DATA, DATA_ACK, RD_DATA, RD_ACK, IGNORE.
  - Localparams for the R/W bit position and the 8-bit byte width.
- Sub-module sccb_line_filter: synchroniser, stability filter and edge/START/STOP detection. Instantiated once with both lines so START/STOP are judged on coherent samples.
- The register file is an inferred 256x8 array inside sccb_responder.

Test Plan:
- Write 8'h42, idx 8'h12, data 8'h80, STOP -> three ACKs (SDA low on each 9th bit); one wr_stb_o with wr_addr_o=8'h12, wr_data_o=8'h80; busy_o falls after STOP.
- Address byte 8'h44 -> nack_o pulses once, SDA never driven low for the rest of the transfer, no wr_stb_o, block idle after STOP.
- Write idx 8'h3A with data 8'h04,8'h11 (AUTO_INC=1) -> wr_stb_o at 8'h3A/8'h04 then 8'h3B/8'h11.
- Then write 8'h42 + idx 8'h3A, Sr, read 8'h43, master reads two bytes (ACK, then NACK) -> SDA carries 8'h04 then 8'h11; SDA released after the NACK.
- Write idx 8'hFF with data 8'hAA,8'hBB -> writes to 8'hFF then 8'h00 (wrap).
- STOP after 4 data bits, then separately rst asserted while ACK is driven -> no write strobe for the partial byte; sda_oen_o=1 on the clk after rst, state IDLE, regfile cleared.

Source files
------------

// File: rtl/sccb_responder_pkg.sv
// sccb_responder_pkg
//   Shared types and constants for the SCCB responder: the protocol state
//   enum, byte geometry, line indices used by the line filter, and the
//   register-index advance helper.
package sccb_responder_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        ADDR_ACK,
        REG_IDX,
        IDX_ACK,
        WR_DATA,
        DATA_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } sccb_state_e;

    localparam int BYTE_W = 8;  // bits per SCCB byte
    localparam int RW_BIT = 0;  // R/W flag position in the address byte

    // Line positions inside the filter's 2-bit line vectors.
    localparam int LINE_SDA = 0;
    localparam int LINE_SCL = 1;

    // Index after a data byte: wraps 8'hFF -> 8'h00 naturally.
    function automatic logic [BYTE_W-1:0] next_idx(input logic [BYTE_W-1:0] idx,
                                                   input logic             inc);
        return inc ? idx + BYTE_W'(1) : idx;
    endfunction

endpackage

// File: rtl/sccb_responder_if.sv
// sccb_responder_if
//   Two-wire bus pads plus the write-strobe / status outputs of the responder.
//   slave  : responder side (consumes pads, produces drive + strobes)
//   master : bus/bench side
//   scl_i, sda_i    raw pad inputs
//   sda_oen_o       SDA enable, active-low (0 pulls SDA low, 1 releases)
//   wr_stb_o        one-cycle pulse per committed data byte
//   wr_addr_o/data  index/data of the committed byte
//   busy_o          transfer in progress toward this device
//   nack_o          one-cycle pulse when an address byte is ignored
interface sccb_responder_if;
    import sccb_responder_pkg::*;

    logic              scl_i;
    logic              sda_i;
    logic              sda_oen_o;
    logic              wr_stb_o;
    logic [BYTE_W-1:0] wr_addr_o;
    logic [BYTE_W-1:0] wr_data_o;
    logic              busy_o;
    logic              nack_o;

    modport slave (
        input  scl_i, sda_i,
        output sda_oen_o, wr_stb_o, wr_addr_o, wr_data_o, busy_o, nack_o
    );

    modport master (
        output scl_i, sda_i,
        input  sda_oen_o, wr_stb_o, wr_addr_o, wr_data_o, busy_o, nack_o
    );

endinterface

// File: rtl/sccb_line_filter.sv
// sccb_line_filter
//   Conditions SCL and SDA together: 2-flop synchroniser, then a stability
//   filter (a line must differ from its filtered value for FILTER_LEN
//   consecutive samples before the filtered value follows), then edge and
//   START/STOP detection on the filtered pair. Events are registered and
//   appear in the same cycle the filtered value changes, so raw-pad to event
//   latency is 2+FILTER_LEN clk.
//   Inputs : clk, rst (sync, active-high), scl_i, sda_i (raw pads)
//   Outputs: sda_o (filtered SDA), scl_rise_o, scl_fall_o, start_o, stop_o
module sccb_line_filter
    import sccb_responder_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);
    localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      filt_q, filt_d;
    logic [1:0][3:0] cnt_q, cnt_d;
    logic            scl_rise_q, scl_rise_d;
    logic            scl_fall_q, scl_fall_d;
    logic            start_q, start_d;
    logic            stop_q, stop_d;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i]  = '0;
            filt_d[i] = filt_q[i];
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_MAX) filt_d[i] = sync2_q[i];
                else                     cnt_d[i]  = cnt_q[i] + 4'd1;
            end
        end
        scl_rise_d = filt_d[LINE_SCL] & ~filt_q[LINE_SCL];
        scl_fall_d = ~filt_d[LINE_SCL] & filt_q[LINE_SCL];
        // START/STOP only while SCL is high on both the old and new sample.
        start_d = filt_q[LINE_SCL] & filt_d[LINE_SCL] & filt_q[LINE_SDA] & ~filt_d[LINE_SDA];
        stop_d  = filt_q[LINE_SCL] & filt_d[LINE_SCL] & ~filt_q[LINE_SDA] & filt_d[LINE_SDA];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Idle bus is high on both lines.
            sync1_q    <= '1;
            sync2_q    <= '1;
            filt_q     <= '1;
            cnt_q      <= '0;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            sync1_q    <= {scl_i, sda_i};
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign sda_o      = filt_q[LINE_SDA];
    assign scl_rise_o = scl_rise_q;
    assign scl_fall_o = scl_fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/sccb_responder.sv
// sccb_responder
//   SCCB/I2C target emulating the OV7670 register interface (7-bit device
//   address, 8-bit register index, 8-bit data) with a 256x8 register file.
//   Every committed write is reported on the wr_* strobe outputs.
//   Ports: clk, rst (sync, active-high), bus (sccb_responder_if.slave).
//   SDA is only ever pulled low; its drive changes one clk after a filtered
//   SCL fall so the master's hold time is respected. SCL is never stretched.
module sccb_responder
    import sccb_responder_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = 7'h21,
    parameter int         FILTER_LEN  = 3,
    parameter bit         AUTO_INC    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    sccb_responder_if.slave bus
);
    localparam int REGS = 256;

    sccb_state_e       state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [BYTE_W-1:0] idx_q, idx_d;
    logic [BYTE_W-1:0] wr_addr_q, wr_addr_d;
    logic [BYTE_W-1:0] wr_data_q, wr_data_d;
    logic              rw_q, rw_d;
    logic              sda_oen_q, sda_oen_d;
    logic              wr_stb_q, wr_stb_d;
    logic              nack_q, nack_d;
    logic              we;

    logic [BYTE_W-1:0] regfile_q [REGS];

    logic              sda_f, scl_rise, scl_fall, start_ev, stop_ev;
    logic [BYTE_W-1:0] byte_in, rd_byte;

    sccb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_line_filter (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (bus.scl_i),
        .sda_i      (bus.sda_i),
        .sda_o      (sda_f),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_ev),
        .stop_o     (stop_ev)
    );

    // Byte as it will look once the bit sampled on this rise is shifted in.
    assign byte_in = {shreg_q[BYTE_W-2:0], sda_f};
    assign rd_byte = regfile_q[idx_q];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        rw_d      = rw_q;
        sda_oen_d = sda_oen_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        nack_d    = 1'b0;
        we        = 1'b0;

        // STOP outranks everything, START outranks bit events.
        if (stop_ev) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oen_d = 1'b1;
        end else if (start_ev) begin
            state_d   = DEV_ADDR;
            bit_cnt_d = '0;
            sda_oen_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE, IGNORE: ;

                DEV_ADDR: if (scl_rise) begin
                    shreg_d = byte_in;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = '0;
                        if (byte_in[BYTE_W-1:1] == DEVICE_ADDR) begin
                            rw_d    = byte_in[RW_BIT];
                            state_d = ADDR_ACK;
                        end else begin
                            nack_d  = 1'b1;
                            state_d = IGNORE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end

                // Ack states: first fall (end of bit 8) pulls SDA low, the
                // next fall (end of the ACK bit) releases it and moves on.
                ADDR_ACK: if (scl_fall) begin
                    if (bit_cnt_q == 4'd0) begin
                        sda_oen_d = 1'b0;
                        bit_cnt_d = 4'd1;
                    end else begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            // Read: present the MSB right away.
                            state_d   = RD_DATA;
                            shreg_d   = rd_byte;
                            sda_oen_d = rd_byte[BYTE_W-1];
                        end else begin
                            state_d   = REG_IDX;
                            sda_oen_d = 1'b1;
                        end
                    end
                end

                REG_IDX: if (scl_rise) begin
                    shreg_d = byte_in;
                    if (bit_cnt_q == 4'd7) begin
                        idx_d     = byte_in;
                        bit_cnt_d = '0;
                        state_d   = IDX_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end

                IDX_ACK: if (scl_fall) begin
                    if (bit_cnt_q == 4'd0) begin
                        sda_oen_d = 1'b0;
                        bit_cnt_d = 4'd1;
                    end else begin
                        sda_oen_d = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = WR_DATA;
                    end
                end

                WR_DATA: if (scl_rise) begin
                    shreg_d = byte_in;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = '0;
                        state_d   = DATA_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end

                DATA_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oen_d = 1'b0;
                            bit_cnt_d = 4'd1;
                        end else begin
                            sda_oen_d = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = WR_DATA;
                        end
                    end else if (scl_rise && bit_cnt_q == 4'd1) begin
                        // Commit on the ACK-bit rise; count 2 marks it done.
                        we        = 1'b1;
                        wr_stb_d  = 1'b1;
                        wr_addr_d = idx_q;
                        wr_data_d = shreg_q;
                        idx_d     = next_idx(idx_q, AUTO_INC);
                        bit_cnt_d = 4'd2;
                    end
                end

                // bit_cnt counts master samples; count 0 on a fall means the
                // byte has not been loaded yet (entry from RD_ACK).
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            shreg_d   = rd_byte;
                            sda_oen_d = rd_byte[BYTE_W-1];
                        end else if (bit_cnt_q == 4'd8) begin
                            sda_oen_d = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = RD_ACK;
                        end else begin
                            shreg_d   = {shreg_q[BYTE_W-2:0], 1'b0};
                            sda_oen_d = shreg_q[BYTE_W-2];
                        end
                    end else if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end

                RD_ACK: if (scl_rise) begin
                    bit_cnt_d = '0;
                    if (!sda_f) begin
                        idx_d   = next_idx(idx_q, AUTO_INC);
                        state_d = RD_DATA;
                    end else begin
                        state_d = IGNORE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            idx_q     <= '0;
            rw_q      <= 1'b0;
            sda_oen_q <= 1'b1;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            rw_q      <= rw_d;
            sda_oen_q <= sda_oen_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            nack_q    <= nack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) regfile_q[i] <= '0;
        end else if (we) begin
            regfile_q[idx_q] <= shreg_q;
        end
    end

    assign bus.sda_oen_o = sda_oen_q;
    assign bus.wr_stb_o  = wr_stb_q;
    assign bus.wr_addr_o = wr_addr_q;
    assign bus.wr_data_o = wr_data_q;
    assign bus.nack_o    = nack_q;
    assign bus.busy_o    = (state_q != IDLE) && (state_q != IGNORE);

endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder
//   Bit-banged SCCB master on a wired-AND SDA line, a strobe/nack monitor,
//   and a register-file model (array + index) used to predict writes and
//   read-back data.
module tb_sccb_responder;

    localparam int H = 16;  // clk per SCL half period

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    always #5 clk = ~clk;

    sccb_responder_if bus ();
    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & bus.sda_oen_o;

    sccb_responder #(
        .DEVICE_ADDR (7'h21),
        .FILTER_LEN  (3),
        .AUTO_INC    (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_rf [256];
    logic [7:0] model_idx;

    logic [7:0] stb_a [$];
    logic [7:0] stb_d [$];
    int nack_cnt    = 0;
    int oen_low_cnt = 0;

    always @(negedge clk) begin
        if (bus.wr_stb_o) begin
            stb_a.push_back(bus.wr_addr_o);
            stb_d.push_back(bus.wr_data_o);
        end
        if (bus.nack_o) nack_cnt++;
        if (!bus.sda_oen_o) oen_low_cnt++;
    end

    typedef struct {
        logic [7:0] dev;
        logic [7:0] idx;
        logic [7:0] d0;
        logic [7:0] d1;
        int         n;
        logic       exp_ack;
        int         exp_nstb;
        logic [7:0] a0;
        logic [7:0] a1;
    } vec_t;

    vec_t vt [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic s);
        wclk(H/2); sda_m = b;
        wclk(H/2); scl_m = 1'b1;
        wclk(H/2); s = bus.sda_i;
        wclk(H/2); scl_m = 1'b0;
    endtask

    task automatic start_c();
        wclk(H/2); sda_m = 1'b1;
        wclk(H/2); scl_m = 1'b1;
        wclk(H/2); sda_m = 1'b0;
        wclk(H/2); scl_m = 1'b0;
    endtask

    task automatic stop_c();
        wclk(H/2); sda_m = 1'b0;
        wclk(H/2); scl_m = 1'b1;
        wclk(H/2); sda_m = 1'b1;
        wclk(H);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(~mack, s);
    endtask

    task automatic write_txn(input logic [7:0] dev, input logic [7:0] idx,
                             input logic [2:0][7:0] d, input int n,
                             output logic [4:0] acks);
        logic a;
        acks = '0;
        start_c();
        write_byte(dev, a); acks[0] = a;
        write_byte(idx, a); acks[1] = a;
        for (int k = 0; k < n; k++) begin
            write_byte(d[k], a);
            acks[2+k] = a;
        end
        stop_c();
    endtask

    // Set index by a write, repeated START, read n bytes (ACK all but last).
    task automatic do_read(input logic [7:0] idx, input int n, input string tag);
        logic a;
        logic [7:0] d;
        logic [7:0] ea;
        start_c();
        write_byte(8'h42, a); chk({tag, "_ack_w"}, 32'(a), 32'd1);
        write_byte(idx, a);   chk({tag, "_ack_idx"}, 32'(a), 32'd1);
        start_c();
        write_byte(8'h43, a); chk({tag, "_ack_r"}, 32'(a), 32'd1);
        chk({tag, "_busy_rd"}, 32'(bus.busy_o), 32'd1);
        for (int k = 0; k < n; k++) begin
            read_byte(k < n - 1, d);
            ea = idx + 8'(k);
            chk($sformatf("%s_rd%0d", tag, k), 32'(d), 32'(model_rf[ea]));
        end
        chk({tag, "_oen_after_nack"}, 32'(bus.sda_oen_o), 32'd1);
        chk({tag, "_busy_after_nack"}, 32'(bus.busy_o), 32'd0);
        stop_c();
        model_idx = idx + 8'(n - 1);
    endtask

    // Read from the preserved index without writing one first.
    task automatic rd_plain(input int n, input string tag);
        logic a;
        logic [7:0] d;
        logic [7:0] ea;
        start_c();
        write_byte(8'h43, a); chk({tag, "_ack_r"}, 32'(a), 32'd1);
        for (int k = 0; k < n; k++) begin
            read_byte(k < n - 1, d);
            ea = model_idx + 8'(k);
            chk($sformatf("%s_rd%0d", tag, k), 32'(d), 32'(model_rf[ea]));
        end
        stop_c();
        model_idx = model_idx + 8'(n - 1);
    endtask

    initial begin
        #900000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] acks;
        logic [2:0][7:0] dv;
        logic s;
        int s0, n0, o0, n, nb;
        logic [7:0] ridx, ea;

        for (int i = 0; i < 256; i++) model_rf[i] = 8'h00;
        model_idx = 8'h00;

        vt[0] = '{8'h42, 8'h12, 8'h80, 8'h00, 1, 1'b1, 1, 8'h12, 8'h00};
        vt[1] = '{8'h44, 8'h12, 8'h5A, 8'h00, 1, 1'b0, 0, 8'h00, 8'h00};
        vt[2] = '{8'h42, 8'h3A, 8'h04, 8'h11, 2, 1'b1, 2, 8'h3A, 8'h3B};
        vt[3] = '{8'h42, 8'hFF, 8'hAA, 8'hBB, 2, 1'b1, 2, 8'hFF, 8'h00};

        // Reset state
        wclk(6);
        chk("rst_oen",     32'(bus.sda_oen_o), 32'd1);
        chk("rst_stb",     32'(bus.wr_stb_o),  32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr_o), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data_o), 32'd0);
        chk("rst_busy",    32'(bus.busy_o),    32'd0);
        chk("rst_nack",    32'(bus.nack_o),    32'd0);
        rst = 1'b0;
        wclk(8);

        // Table-driven write transactions
        for (int v = 0; v < 4; v++) begin
            s0 = stb_a.size();
            n0 = nack_cnt;
            o0 = oen_low_cnt;
            dv = {8'h00, vt[v].d1, vt[v].d0};
            write_txn(vt[v].dev, vt[v].idx, dv, vt[v].n, acks);
            for (int k = 0; k < 2 + vt[v].n; k++)
                chk($sformatf("v%0d_ack%0d", v, k), 32'(acks[k]), 32'(vt[v].exp_ack));
            chk($sformatf("v%0d_nstb", v), 32'(stb_a.size() - s0), 32'(vt[v].exp_nstb));
            for (int k = 0; k < vt[v].exp_nstb; k++) begin
                if (s0 + k < stb_a.size()) begin
                    chk($sformatf("v%0d_addr%0d", v, k), 32'(stb_a[s0+k]), 32'(k == 0 ? vt[v].a0 : vt[v].a1));
                    chk($sformatf("v%0d_data%0d", v, k), 32'(stb_d[s0+k]), 32'(k == 0 ? vt[v].d0 : vt[v].d1));
                end
                model_rf[k == 0 ? vt[v].a0 : vt[v].a1] = (k == 0) ? vt[v].d0 : vt[v].d1;
            end
            chk($sformatf("v%0d_nack_pulses", v), 32'(nack_cnt - n0), 32'(!vt[v].exp_ack));
            if (!vt[v].exp_ack)
                chk($sformatf("v%0d_oen_never_low", v), 32'(oen_low_cnt - o0), 32'd0);
            else
                model_idx = vt[v].idx + 8'(vt[v].n);
            chk($sformatf("v%0d_busy_after_stop", v), 32'(bus.busy_o), 32'd0);
        end

        // Index write, Sr, two-byte read, then read from preserved index
        do_read(8'h3A, 2, "rd3a");
        rd_plain(1, "rdplain");

        // STOP after four data bits: nothing committed
        s0 = stb_a.size();
        start_c();
        write_byte(8'h42, s);
        write_byte(8'h50, s);
        send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b1, s);
        stop_c();
        chk("partial_nstb", 32'(stb_a.size() - s0), 32'd0);
        chk("partial_busy", 32'(bus.busy_o), 32'd0);
        model_idx = 8'h50;
        rd_plain(1, "partial_rd");

        // Randomised writes with read-back against the model
        for (int it = 0; it < 7; it++) begin
            ridx = 8'($urandom_range(0, 255));
            n    = $urandom_range(1, 3);
            for (int k = 0; k < 3; k++) dv[k] = 8'($urandom);
            s0 = stb_a.size();
            write_txn(8'h42, ridx, dv, n, acks);
            chk($sformatf("rnd%0d_acks", it), 32'(acks), 32'((5'd1 << (2 + n)) - 5'd1));
            nb = stb_a.size() - s0;
            chk($sformatf("rnd%0d_nstb", it), 32'(nb), 32'(n));
            for (int k = 0; k < n; k++) begin
                ea = ridx + 8'(k);
                if (k < nb) begin
                    chk($sformatf("rnd%0d_addr%0d", it, k), 32'(stb_a[s0+k]), 32'(ea));
                    chk($sformatf("rnd%0d_data%0d", it, k), 32'(stb_d[s0+k]), 32'(dv[k]));
                end
                model_rf[ea] = dv[k];
            end
            do_read(ridx, n, $sformatf("rnd%0d", it));
        end

        // Reset while the address ACK is being driven
        start_c();
        for (int i = 7; i >= 0; i--) send_bit(((8'h42 >> i) & 8'h01) != 0, s);
        wclk(H/2); sda_m = 1'b1;
        wclk(H/2); scl_m = 1'b1;
        wclk(H/2);
        chk("ack_driven_before_rst", 32'(bus.sda_oen_o), 32'd0);
        rst = 1'b1;
        wclk(1);
        chk("oen_after_rst",  32'(bus.sda_oen_o), 32'd1);
        chk("busy_after_rst", 32'(bus.busy_o),    32'd0);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) model_rf[i] = 8'h00;
        model_idx = 8'h00;
        wclk(H/2); scl_m = 1'b0;
        stop_c();
        do_read(8'h12, 1, "post_rst_12");
        do_read(8'h3A, 2, "post_rst_3a");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
